// File: rtl/id_ex_stage_pkg.sv
// Shared 16-bit datapath definitions: opCodes, instruction field positions,
// and the decode helpers used by the ID/EX stage.
package id_ex_stage_pkg;

   localparam int WORD_W  = 16;
   localparam int FIELD_W = 4;
   localparam int IMM_W   = 8;

   // Instruction field positions: [15:12] opCode, [11:8] op1, [7:4] op2, [3:0] funCode.
   localparam int OPC_LSB = 12;
   localparam int OP1_LSB = 8;
   localparam int OP2_LSB = 4;
   localparam int FUN_LSB = 0;

   // opCodes seen by ALU control; funCode only matters for OP_RTYPE.
   typedef enum logic [FIELD_W-1:0] {
      OP_RTYPE = 4'h0,
      OP_ADDI  = 4'h1,
      OP_ANDI  = 4'h2,
      OP_ORI   = 4'h3,
      OP_LUI   = 4'h4,
      OP_LOAD  = 4'h8,
      OP_STORE = 4'h9,
      OP_BEQ   = 4'hA,
      OP_BNE   = 4'hB,
      OP_JMP   = 4'hC
   } opCode_e;

   // Contents of the ID/EX pipeline register.
   typedef struct packed {
      logic               valid;
      logic [FIELD_W-1:0] opCode;
      logic [FIELD_W-1:0] funCode;
      logic [FIELD_W-1:0] op1;
      logic [FIELD_W-1:0] op2;
      logic [WORD_W-1:0]  imm;
      logic [WORD_W-1:0]  pc;
   } exFields_t;

   // Sign-extend the 8-bit immediate field to a full word.
   function automatic logic [WORD_W-1:0] signExtImm(input logic [WORD_W-1:0] instr);
      return {{(WORD_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
   endfunction

   // Purely positional decode; no field is qualified by opCode.
   function automatic exFields_t decode(input logic valid,
                                        input logic [WORD_W-1:0] instr,
                                        input logic [WORD_W-1:0] pc);
      exFields_t f;
      f.valid   = valid;
      f.opCode  = instr[OPC_LSB +: FIELD_W];
      f.funCode = instr[FUN_LSB +: FIELD_W];
      f.op1     = instr[OP1_LSB +: FIELD_W];
      f.op2     = instr[OP2_LSB +: FIELD_W];
      f.imm     = signExtImm(instr);
      f.pc      = pc;
      return f;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// (op1) is read by the instruction waiting in IF/ID.
module hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter logic [FIELD_W-1:0] LOAD_OP = OP_LOAD
) (
   input  logic               exValid,
   input  logic [FIELD_W-1:0] exOpCode,
   input  logic [FIELD_W-1:0] exOp1,
   input  logic               ifValid,
   input  logic [FIELD_W-1:0] ifOp1,
   input  logic [FIELD_W-1:0] ifOp2,
   output logic               hazard
);

   // op1 is both a source and the destination, so both source fields are compared.
   assign hazard = exValid & (exOpCode == LOAD_OP) & ifValid
                 & ((ifOp1 == exOp1) | (ifOp2 == exOp1));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes the IF/ID instruction into EX fields, inserts one
// bubble per load-use hazard, honours EX backpressure and branch flushes, and
// counts inserted bubbles with a saturating counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter logic [3:0] LOAD_OP = 4'b1000,
   parameter int          CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [WORD_W-1:0] if_instr,
   input  logic [WORD_W-1:0] if_pc,
   output logic              id_ready,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [3:0]        ex_opCode,
   output logic [3:0]        ex_funCode,
   output logic [3:0]        ex_op1,
   output logic [3:0]        ex_op2,
   output logic [WORD_W-1:0] ex_imm,
   output logic [WORD_W-1:0] ex_pc,
   output logic [CNT_W-1:0]  bubble_count
);

   exFields_t exQ;
   exFields_t ifDec;
   logic      hazard;

   hazard_detect #(
      .LOAD_OP (LOAD_OP)
   ) hazardDetect (
      .exValid  (exQ.valid),
      .exOpCode (exQ.opCode),
      .exOp1    (exQ.op1),
      .ifValid  (if_valid),
      .ifOp1    (if_instr[OP1_LSB +: FIELD_W]),
      .ifOp2    (if_instr[OP2_LSB +: FIELD_W]),
      .hazard   (hazard)
   );

   assign ifDec = decode(if_valid, if_instr, if_pc);

   // A flush overrides the hazard: the waiting instruction is consumed and dropped.
   assign id_ready = ex_ready & (flush | ~hazard);

   // Pipeline register and bubble counter: reset, hold, flush, bubble or load.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of its neighbours.
      if (rst) begin
         exQ          <= '0;
         bubble_count <= '0;
      end else if (ex_ready) begin
         if (flush) begin
            exQ <= '0;
         end else if (hazard) begin
            // The bubble sits in EX next cycle, which clears the hazard term (one bubble per load).
            exQ <= '0;
            if (bubble_count != '1)
               bubble_count <= bubble_count + CNT_W'(1);
         end else begin
            exQ <= ifDec;
         end
      end
   end

   assign ex_valid   = exQ.valid;
   assign ex_opCode  = exQ.opCode;
   assign ex_funCode = exQ.funCode;
   assign ex_op1     = exQ.op1;
   assign ex_op2     = exQ.op2;
   assign ex_imm     = exQ.imm;
   assign ex_pc      = exQ.pc;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 16-bit datapath. Accepts a fetched instruction from IF/ID, splits it into opCode, funCode, register fields and immediate, and registers them for EX, where opCode/funCode drive ALU control. Detects load-use hazards, inserts one bubble and stalls upstream. Also honours downstream backpressure and branch flushes, and counts inserted bubbles.

## Interface
Parameters:
- LOAD_OP, 4'b1000: opCode of the load instruction (result available only after MEM).
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  16  instruction: [15:12] opCode, [11:8] op1 (source and destination), [7:4] op2 (source), [3:0] funCode; [7:0] is the immediate field.
- if_pc  in  16  PC of if_instr.
- id_ready  out  1  combinational; stage accepts if_instr this cycle.
- flush  in  1  branch taken in EX; discard decode-stage instruction.
- ex_ready  in  1  EX can accept a new instruction this cycle.
- ex_valid  out  1  EX outputs hold a real instruction (0 = bubble).
- ex_opCode  out  4  registered instr[15:12].
- ex_funCode  out  4  registered instr[3:0].
- ex_op1  out  4  registered instr[11:8].
- ex_op2  out  4  registered instr[7:4].
- ex_imm  out  16  registered sign-extension of instr[7:0].
- ex_pc  out  16  registered if_pc.
- bubble_count  out  CNT_W  saturating count of load-use bubbles.

## Operation
- Define `hazard` = ex_valid & (ex_opCode == LOAD_OP) & if_valid & ((if_instr[11:8] == ex_op1) | (if_instr[7:4] == ex_op1)).
- Define `advance` = ex_ready.
- Cycle action, in priority order:
  1. rst: all outputs and bubble_count go to 0.
  2. !advance: all ex_* registers and bubble_count hold.
  3. flush: ex_valid <= 0; ex_* fields are don't-care (implementation drives 0); the IF/ID instruction is consumed and dropped; no bubble is counted.
  4. hazard: ex_valid <= 0 (bubble); bubble_count increments, saturating at all-ones.
  5. Otherwise: ex_valid <= if_valid; all fields load from if_instr and if_pc.
- id_ready = advance & (flush | !hazard). An instruction transfers when if_valid & id_ready.
- Field decoding is purely positional, with no opCode qualification. funCode is passed through for every opCode; ALU control ignores it when opCode != 0.
- The stage has two effective states, RUN and STALL:
  - RUN to STALL on hazard & advance & !flush.
  - STALL to RUN on the next advancing cycle: the bubble now sits in EX, so the hazard term is false.
  - A hazard lasts exactly 1 bubble per load.

## Timing
- Latency: 1 cycle from the accepting edge to the ex_* outputs.
- Throughput: 1 instruction per cycle absent hazards and backpressure.
- id_ready is a combinational function of ex_* registers, if_*, flush and ex_ready. There is no combinational path from if_instr to any ex_* output.
- Simultaneous flush and hazard: flush wins. There is no bubble count and id_ready = 1.
- Simultaneous flush and !ex_ready: hold wins. The flush is ignored that cycle, and the upstream must keep flush asserted until ex_ready.
- Back-to-back loads where the second depends on the first: 1 bubble, then the second load enters EX, and it can itself stall its consumer.
- Load with op1 equal to both sources of the next instruction: still exactly 1 bubble.
- bubble_count at all-ones stays at all-ones.
- rst asserted mid-stall: the next cycle has ex_valid = 0 and id_ready = ex_ready, because there is no pending hazard.

## Structure
- Shared datapath package/header holds: opCode constants (R-type 0, LOAD_OP 8, and the others used by ALU control), instruction field bit positions, and the 16-bit word width.
- One natural sub-module, `hazard_detect`: combinational, producing `hazard` from the EX fields and if_instr. The pipeline register and counter stay in id_ex_stage.

## Test plan
- R-type passthrough: if_instr = 16'h0345 with if_valid, no hazard → next cycle ex_opCode = 0, ex_op1 = 3, ex_op2 = 4, ex_funCode = 5, ex_valid = 1.
- Sign extension: if_instr = 16'h1_2_F0 (opCode 1, imm 8'hF0) → ex_imm = 16'hFFF0; 16'h1270 → ex_imm = 16'h0070.
- Load-use: load 16'h8200, then 16'h0320 (op2 = 2) → first cycle ex_valid = 0, id_ready = 0, bubble_count = 1; following cycle ex_opCode = 0, ex_op2 = 2, ex_valid = 1.
- Flush vs hazard: hazard condition set up with flush = 1 → ex_valid = 0, id_ready = 1, bubble_count unchanged.
- Backpressure: ex_ready = 0 for 3 cycles mid-stream → ex_* held, id_ready = 0, bubble_count held; resumes correctly when ex_ready = 1.
- Saturation/reset: CNT_W = 2, force 4 load-use hazards → bubble_count = 3; then rst for 1 cycle → all outputs 0.
